// File: rtl/tdc_stats_accum.sv
// Batch statistics over TDC time codes: averages, min/max and overflow-code count
// across 2^LOG2_N accepted samples, latched at batch end for readout on one bus.
module tdc_stats_accum #(
    parameter int CODE_W = 8,
    parameter int LOG2_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    input  logic              start,
    input  logic [1:0]        sel,
    output logic [CODE_W-1:0] result,
    output logic              busy,
    output logic              done
);

    localparam int SUM_W = CODE_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [SUM_W-1:0]  sum, sum_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CODE_W-1:0] wmin, wmax, wsat;
    logic [CODE_W-1:0] min_nxt, max_nxt, sat_nxt;
    logic [CODE_W-1:0] stat_avg, stat_min, stat_max, stat_sat;
    logic              accept, last;

    // Overflow-code counter sticks at all-ones instead of wrapping.
    function automatic logic [CODE_W-1:0] sat_inc(input logic [CODE_W-1:0] v);
        return (v == {CODE_W{1'b1}}) ? v : v + CODE_W'(1);
    endfunction

    always_comb begin
        accept    = (state == ACCUM) && code_valid && !start;
        last      = accept && (cnt == LAST_CNT);
        sum_nxt   = sum + {{LOG2_N{1'b0}}, code_in};
        min_nxt   = (code_in < wmin) ? code_in : wmin;
        max_nxt   = (code_in > wmax) ? code_in : wmax;
        sat_nxt   = (code_in == {CODE_W{1'b1}}) ? sat_inc(wsat) : wsat;
        state_nxt = state;
        if (start)
            state_nxt = ACCUM;
        else if (last)
            state_nxt = DONE;
    end

    assign busy = (state == ACCUM);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sum   <= '0;
            cnt   <= '0;
            wmin  <= '1;
            wmax  <= '0;
            wsat  <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                sum  <= '0;
                cnt  <= '0;
                wmin <= '1;
                wmax <= '0;
                wsat <= '0;
            end else if (accept) begin
                sum  <= sum_nxt;
                cnt  <= cnt + CNT_W'(1);
                wmin <= min_nxt;
                wmax <= max_nxt;
                wsat <= sat_nxt;
            end
        end
    end

    // Latched stats include the final sample; they survive later starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_avg <= '0;
            stat_min <= '0;
            stat_max <= '0;
            stat_sat <= '0;
        end else if (last) begin
            stat_avg <= sum_nxt[SUM_W-1:LOG2_N];
            stat_min <= min_nxt;
            stat_max <= max_nxt;
            stat_sat <= sat_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else begin
            unique case (sel)
                2'b00:   result <= stat_avg;
                2'b01:   result <= stat_min;
                2'b10:   result <= stat_max;
                default: result <= stat_sat;
            endcase
        end
    end

endmodule
